// File: rtl/aes_scan_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Package : aes_scan_pkg                                                    |
// | FSM encoding and known-answer golden responses for aes_scan_test_ctrl.    |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
package aes_scan_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_INIT  = 4'd1,
    ST_KWAIT = 4'd2,
    ST_NEXT  = 4'd3,
    ST_BWAIT = 4'd4,
    ST_CAPT  = 4'd5,
    ST_CMP   = 4'd6,
    ST_SHIFT = 4'd7,
    ST_FIN   = 4'd8
  } state_t;

  localparam logic [127:0] GOLDEN_128 = 128'hb72b9cdb6330f947c36462aa274c0cfe;
  localparam logic [127:0] GOLDEN_256 = 128'h613094199cda154b20c216dd0944002f;

  function automatic logic [127:0] golden_for(input logic keylen);
    return keylen ? GOLDEN_256 : GOLDEN_128;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_scan_shifter.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module : aes_scan_shifter                                                 |
// | 128-bit MSB-first PISO with valid/ready handshake and 7-bit bit index.    |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module aes_scan_shifter (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [127:0] load_data,
  input  logic         ready,
  output logic         valid,
  output logic         data,
  output logic         last
);

  logic [127:0] sreg;
  logic [6:0]   idx;
  logic         active;
  logic         fire;

  assign fire  = active & ready;
  assign valid = active;
  assign data  = sreg[127];
  assign last  = fire && (idx == 7'd127);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sreg   <= '0;
      idx    <= '0;
      active <= 1'b0;
    end else if (load) begin
      sreg   <= load_data;
      idx    <= '0;
      active <= 1'b1;
    end else if (fire) begin
      // Clear the register as it drains so no response bits linger.
      sreg <= {sreg[126:0], 1'b0};
      idx  <= idx + 7'd1;
      if (idx == 7'd127) active <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/aes_scan_test_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module : aes_scan_test_ctrl                                               |
// | Secure-scan known-answer test initiator for aes_core. Defining macro      |
// | AES_SCAN_RAW_OUT_EN enables the serial dump of the captured response.     |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module aes_scan_test_ctrl
  import aes_scan_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         test_start,
  input  logic         test_keylen,
  input  logic         core_ready,
  input  logic         core_result_valid,
  input  logic         core_faults,
  input  logic [127:0] core_scanout,
  output logic         core_init,
  output logic         core_next,
  output logic         core_encdec,
  output logic         core_keylen,
  output logic         core_scan_mode,
  output logic         core_en_scan_in,
  output logic         core_en_scan_out,
  output logic         core_loadkey,
  output logic         so_data,
  output logic         so_valid,
  input  logic         so_ready,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic         timeout,
  output logic         fault_abort
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic             keylen_q;
  logic             start_test, set_timeout, set_fault, cmp_load, shift_last;
  logic             pre_shift, timed_out;

`ifdef AES_SCAN_RAW_OUT_EN
  localparam bit RAW_OUT = 1'b1;

  aes_scan_shifter u_shifter (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (cmp_load),
    .load_data (core_scanout),
    .ready     (so_ready),
    .valid     (so_valid),
    .data      (so_data),
    .last      (shift_last)
  );
`else
  localparam bit RAW_OUT = 1'b0;
  // Secure build: the response is only compared, never stored or exported.
  logic unused_so_ready;
  assign unused_so_ready = so_ready;
  assign so_valid        = 1'b0;
  assign so_data         = 1'b0;
  assign shift_last      = 1'b0;
`endif

  assign pre_shift = state inside {ST_INIT, ST_KWAIT, ST_NEXT, ST_BWAIT, ST_CAPT, ST_CMP};
  assign timed_out = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next  = state;
    start_test  = 1'b0;
    set_timeout = 1'b0;
    set_fault   = 1'b0;
    cmp_load    = 1'b0;
    case (state)
      ST_IDLE:  if (test_start) begin
                  start_test = 1'b1;
                  state_next = ST_INIT;
                end
      ST_INIT:  state_next = ST_KWAIT;
      // Ready is stale in the first KWAIT cycle (cnt==0); the core drops it a cycle after init.
      ST_KWAIT: if ((cnt != '0) && core_ready) state_next = ST_NEXT;
                else if (timed_out) begin
                  set_timeout = 1'b1;
                  state_next  = ST_FIN;
                end
      ST_NEXT:  state_next = ST_BWAIT;
      ST_BWAIT: if (core_result_valid) state_next = ST_CAPT;
                else if (timed_out) begin
                  set_timeout = 1'b1;
                  state_next  = ST_FIN;
                end
      ST_CAPT:  state_next = ST_CMP;
      ST_CMP:   begin
                  cmp_load   = 1'b1;
                  state_next = RAW_OUT ? ST_SHIFT : ST_FIN;
                end
      ST_SHIFT: if (shift_last) state_next = ST_FIN;
      ST_FIN:   state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
    if (core_faults && pre_shift) begin
      set_fault   = 1'b1;
      set_timeout = 1'b0;
      cmp_load    = 1'b0;
      state_next  = ST_FIN;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      cnt <= '0;
    else if ((state_next != state) && ((state_next == ST_KWAIT) || (state_next == ST_BWAIT)))
      cnt <= '0;
    else if ((state == ST_KWAIT) || (state == ST_BWAIT))
      cnt <= cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      keylen_q    <= 1'b0;
      pass        <= 1'b0;
      timeout     <= 1'b0;
      fault_abort <= 1'b0;
    end else begin
      if (start_test) begin
        keylen_q    <= test_keylen;
        pass        <= 1'b0;
        timeout     <= 1'b0;
        fault_abort <= 1'b0;
      end
      if (cmp_load) pass <= (core_scanout == golden_for(keylen_q));
      if (set_timeout) begin
        timeout <= 1'b1;
        pass    <= 1'b0;
      end
      if (set_fault) begin
        fault_abort <= 1'b1;
        pass        <= 1'b0;
      end
    end
  end

  assign busy             = (state != ST_IDLE) && (state != ST_FIN);
  assign done             = (state == ST_FIN);
  assign core_init        = (state == ST_INIT);
  assign core_next        = (state == ST_NEXT);
  assign core_encdec      = busy;
  assign core_keylen      = keylen_q;
  assign core_scan_mode   = busy;
  // en_scan_in=en_scan_out=1, loadkey=0 is the only scan combination the core accepts without faulting.
  assign core_en_scan_in  = busy;
  assign core_en_scan_out = busy;
  assign core_loadkey     = ~busy;

endmodule
`default_nettype wire

// File: tb/tb_aes_scan_test_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module : tb_aes_scan_test_ctrl                                            |
// | Table-driven bench for aes_scan_test_ctrl with a reactive aes_core model. |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module tb_aes_scan_test_ctrl;

  localparam logic [127:0] G128 = 128'hb72b9cdb6330f947c36462aa274c0cfe;
  localparam logic [127:0] G256 = 128'h613094199cda154b20c216dd0944002f;
  localparam int           TO   = 255;
  localparam logic [14:0]  RST_OUTS = 15'h0080;

  logic clk = 1'b0, reset_n = 1'b0, test_start = 1'b0, test_keylen = 1'b0;
  logic core_ready, core_result_valid, core_faults = 1'b0, so_ready = 1'b1;
  logic [127:0] core_scanout;
  logic core_init, core_next, core_encdec, core_keylen, core_scan_mode;
  logic core_en_scan_in, core_en_scan_out, core_loadkey, so_data, so_valid;
  logic busy, done, pass, timeout, fault_abort;

  always #5 clk = ~clk;

  aes_scan_test_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .test_start(test_start), .test_keylen(test_keylen),
    .core_ready(core_ready), .core_result_valid(core_result_valid), .core_faults(core_faults),
    .core_scanout(core_scanout), .core_init(core_init), .core_next(core_next),
    .core_encdec(core_encdec), .core_keylen(core_keylen), .core_scan_mode(core_scan_mode),
    .core_en_scan_in(core_en_scan_in), .core_en_scan_out(core_en_scan_out),
    .core_loadkey(core_loadkey), .so_data(so_data), .so_valid(so_valid), .so_ready(so_ready),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout), .fault_abort(fault_abort)
  );

  // aes_core model: ready drops one cycle after init; ScanOut updates one cycle after result_valid.
  logic [127:0] model_resp = '0;
  int  rdy_dly = 2, val_dly = 3, kcnt, bcnt;
  bit  never_valid = 1'b0, kbusy, bbusy, scan_pend;
  logic init_d;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      core_ready <= 1'b1; core_result_valid <= 1'b0; core_scanout <= '0;
      init_d <= 1'b0; kbusy <= 1'b0; bbusy <= 1'b0; scan_pend <= 1'b0; kcnt <= 0; bcnt <= 0;
    end else begin
      init_d <= core_init;
      if (scan_pend) begin core_scanout <= model_resp; scan_pend <= 1'b0; end
      if (init_d) begin
        core_ready <= 1'b0; core_result_valid <= 1'b0; core_scanout <= '0;
        kbusy <= 1'b1; kcnt <= rdy_dly; bbusy <= 1'b0;
      end else if (kbusy) begin
        if (kcnt == 0) begin core_ready <= 1'b1; kbusy <= 1'b0; end
        else kcnt <= kcnt - 1;
      end
      if (core_next) begin
        core_ready <= 1'b0; core_result_valid <= 1'b0; bbusy <= 1'b1; bcnt <= val_dly;
      end else if (bbusy && !never_valid) begin
        if (bcnt == 0) begin
          core_result_valid <= 1'b1; core_ready <= 1'b1; scan_pend <= 1'b1; bbusy <= 1'b0;
        end else bcnt <= bcnt - 1;
      end
    end
  end

  int total = 0, bad = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  function automatic logic [14:0] outs();
    return {core_init, core_next, core_encdec, core_keylen, core_scan_mode, core_en_scan_in,
            core_en_scan_out, core_loadkey, so_data, so_valid, busy, done, pass, timeout, fault_abort};
  endfunction

  task automatic start(input logic kl);
    @(negedge clk); test_keylen = kl; test_start = 1'b1;
    @(negedge clk); test_start = 1'b0;
    check("init_pulse", {core_init, busy}, 2'b11);
    check("keylen_out", core_keylen, kl);
  endtask

  task automatic run_to_done(input logic [127:0] exp_resp, input int stall_at, output bit got_done,
                             output logic [127:0] rx, output int nbits, output int next_at);
    int  stall_left = 0;
    bit  stalled = 1'b0, pins_ok = 1'b1, so_ok = 1'b1;
    got_done = 1'b0; rx = '0; nbits = 0; next_at = -1;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      if (done) begin got_done = 1'b1; break; end
      if (core_next && next_at < 0) next_at = cyc;
      if (!(busy && core_en_scan_in && core_en_scan_out && !core_loadkey && core_scan_mode && core_encdec))
        pins_ok = 1'b0;
`ifdef AES_SCAN_RAW_OUT_EN
      if (so_valid && nbits == stall_at && !stalled) begin stall_left = 5; stalled = 1'b1; end
      if (stall_left > 0) begin
        so_ready = 1'b0; stall_left--;
        check("stall_hold", {so_valid, so_data}, {1'b1, exp_resp[127-nbits]});
      end else begin
        so_ready = 1'b1;
        if (so_valid && nbits < 128) begin rx = {rx[126:0], so_data}; nbits++; end
      end
`else
      if (so_valid || so_data) so_ok = 1'b0;
`endif
    end
    so_ready = 1'b1;
    check("pins_while_busy", pins_ok, 1'b1);
    check("so_quiet", so_ok, 1'b1);
  endtask

  typedef struct {
    logic kl; logic [127:0] resp; int rdy; int val; logic exp_pass; logic exp_first; int stall_at;
  } vec_t;
  vec_t vecs[4];

  initial begin
    bit got_done, found, seen;
    logic [127:0] rx;
    int nbits, next_at, k;

    vecs[0] = '{1'b0, G128,                      2, 3, 1'b1, 1'b1, 20};
    vecs[1] = '{1'b1, G256,                      0, 0, 1'b1, 1'b0, -1};
    vecs[2] = '{1'b0, G128 ^ 128'h1,             5, 1, 1'b0, 1'b1, -1};
    vecs[3] = '{1'b1, G128,                      1, 7, 1'b0, 1'b1, -1};

    repeat (3) @(negedge clk);
    check("in_reset_outs", outs(), RST_OUTS);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_outs", outs(), RST_OUTS);

    for (int i = 0; i < 4; i++) begin
      model_resp = vecs[i].resp; rdy_dly = vecs[i].rdy; val_dly = vecs[i].val;
      start(vecs[i].kl);
      run_to_done(vecs[i].resp, vecs[i].stall_at, got_done, rx, nbits, next_at);
      check($sformatf("v%0d_done", i), got_done, 1'b1);
      check($sformatf("v%0d_init_to_next", i), next_at, vecs[i].rdy + 3);
      check($sformatf("v%0d_pass", i), pass, vecs[i].exp_pass);
      check($sformatf("v%0d_to_fault", i), {timeout, fault_abort}, 2'b00);
      check($sformatf("v%0d_fin_pins", i), {busy, core_en_scan_in, core_en_scan_out, core_loadkey}, 4'b0001);
`ifdef AES_SCAN_RAW_OUT_EN
      check($sformatf("v%0d_nbits", i), nbits, 128);
      check($sformatf("v%0d_first_bit", i), rx[127], vecs[i].exp_first);
      check($sformatf("v%0d_serial", i), rx, vecs[i].resp);
`endif
      if (i == 0) test_start = 1'b1;  // a start during FIN must be ignored
      @(negedge clk);
      test_start = 1'b0;
      check($sformatf("v%0d_after_fin", i), {done, busy, core_init}, 3'b000);
    end

    // Fault during BWAIT
    never_valid = 1'b1;
    start(1'b0);
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin @(negedge clk); if (core_next) begin found = 1'b1; break; end end
    check("fault_next_seen", found, 1'b1);
    @(negedge clk); core_faults = 1'b1;
    @(negedge clk); core_faults = 1'b0;
    check("fault_abort", {done, fault_abort, pass, timeout, core_en_scan_in, core_en_scan_out, core_loadkey},
          7'b1100001);
    @(negedge clk);

    // Timeout in BWAIT, with an ignored start pulse while busy
    start(1'b0);
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin @(negedge clk); if (core_next) begin found = 1'b1; break; end end
    check("to_next_seen", found, 1'b1);
    k = -1;
    for (int c = 1; c < 1000; c++) begin
      @(negedge clk);
      if (c == 10) begin test_start = 1'b1; test_keylen = 1'b1; end
      if (c == 11) test_start = 1'b0;
      if (timeout) begin k = c; break; end
    end
    test_start = 1'b0;
    check("timeout_latency", k, TO + 1);
    check("timeout_flags", {done, pass, fault_abort, core_keylen}, 4'b1000);
    never_valid = 1'b0;
    @(negedge clk);

    // Reset in the middle of a test
    model_resp = G256; rdy_dly = 1; val_dly = 2;
    start(1'b1);
`ifdef AES_SCAN_RAW_OUT_EN
    nbits = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk); so_ready = 1'b1;
      if (so_valid) nbits++;
      if (nbits == 30) break;
    end
    check("reset_mid_shift_reached", nbits, 30);
`else
    for (int c = 0; c < 200; c++) begin @(negedge clk); if (core_next) break; end
    repeat (3) @(negedge clk);
`endif
    #2 reset_n = 1'b0;
    #1 check("reset_mid_outs", outs(), RST_OUTS);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin @(negedge clk); if (done || busy) seen = 1'b1; end
    check("no_done_after_reset", seen, 1'b0);
    check("idle_after_reset", outs(), RST_OUTS);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
